// File: rtl/alu_ex_unit.sv
// Execute-stage ALU: single-cycle integer ops plus iterative MUL/UDIV.
// Results and NZCV flags are registered toward the EX/MEM boundary.
module alu_ex_unit #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic [3:0]       flags_o
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ORR  = 4'h4;
  localparam logic [3:0] OP_EOR  = 4'h5;
  localparam logic [3:0] OP_LSL  = 4'h6;
  localparam logic [3:0] OP_LSR  = 4'h7;
  localparam logic [3:0] OP_ASR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_UDIV = 4'hC;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW:0]     cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             is_div_q;

  logic [WIDTH:0]   sum, dif;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sc_res;
  logic             sc_wr, sc_nz, sc_cv, sc_c, sc_v;
  logic             launch;

  logic [WIDTH-1:0] mul_next;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             take;
  logic [WIDTH-1:0] div_rem_next, div_q_next, step_res;

  assign sum = {1'b0, op_a_i} + {1'b0, op_b_i};
  assign dif = {1'b0, op_a_i} - {1'b0, op_b_i};
  assign sh  = op_b_i[SHW-1:0];

  always_comb begin
    sc_res = '0;
    sc_wr  = 1'b0;
    sc_nz  = 1'b0;
    sc_cv  = 1'b0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (alu_op_i)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0]; sc_wr = 1'b1; sc_nz = 1'b1; sc_cv = 1'b1;
        sc_c   = sum[WIDTH];
        sc_v   = (op_a_i[WIDTH-1] == op_b_i[WIDTH-1]) && (sum[WIDTH-1] != op_a_i[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        // C is NOT borrow; CMP updates flags only
        sc_res = dif[WIDTH-1:0]; sc_wr = (alu_op_i == OP_SUB); sc_nz = 1'b1; sc_cv = 1'b1;
        sc_c   = ~dif[WIDTH];
        sc_v   = (op_a_i[WIDTH-1] != op_b_i[WIDTH-1]) && (dif[WIDTH-1] != op_a_i[WIDTH-1]);
      end
      OP_AND: begin sc_res = op_a_i & op_b_i; sc_wr = 1'b1; sc_nz = 1'b1; end
      OP_ORR: begin sc_res = op_a_i | op_b_i; sc_wr = 1'b1; sc_nz = 1'b1; end
      OP_EOR: begin sc_res = op_a_i ^ op_b_i; sc_wr = 1'b1; sc_nz = 1'b1; end
      OP_LSL: begin sc_res = op_a_i << sh;    sc_wr = 1'b1; sc_nz = 1'b1; end
      OP_LSR: begin sc_res = op_a_i >> sh;    sc_wr = 1'b1; sc_nz = 1'b1; end
      OP_ASR: begin sc_res = WIDTH'($signed(op_a_i) >>> sh); sc_wr = 1'b1; sc_nz = 1'b1; end
      OP_MOV: begin sc_res = op_b_i;          sc_wr = 1'b1; sc_nz = 1'b1; end
      OP_UDIV: begin
        if (op_b_i == '0) begin
          sc_res = '1; sc_wr = 1'b1; sc_nz = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign launch  = (state_q == IDLE) &&
                   ((alu_op_i == OP_MUL) || ((alu_op_i == OP_UDIV) && (op_b_i != '0)));
  assign stall_o = rst_n && !flush_i && ((state_q == RUN) || launch);

  // One iteration step: MUL uses a_q/b_q as shifting multiplicand/multiplier,
  // UDIV uses a_q as dividend-becoming-quotient and acc_q as partial remainder.
  assign mul_next     = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh       = {acc_q, a_q[WIDTH-1]};
  assign rem_sub      = rem_sh - {1'b0, b_q};
  assign take         = ~rem_sub[WIDTH];
  assign div_rem_next = take ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_q_next   = {a_q[WIDTH-2:0], take};
  assign step_res     = is_div_q ? div_q_next : mul_next;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (launch) state_d = RUN;
        RUN:     if (cnt_q == (SHW+1)'(1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      acc_q          <= '0;
      is_div_q       <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      flags_o        <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        cnt_q          <= '0;
        result_valid_o <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (launch) begin
              a_q            <= op_a_i;
              b_q            <= op_b_i;
              acc_q          <= '0;
              is_div_q       <= (alu_op_i == OP_UDIV);
              cnt_q          <= (SHW+1)'(WIDTH);
              result_valid_o <= 1'b0;
            end else begin
              result_valid_o <= sc_wr;
              if (sc_wr) result_o <= sc_res;
              if (sc_nz) flags_o[3:2] <= {sc_res[WIDTH-1], sc_res == '0};
              if (sc_cv) flags_o[1:0] <= {sc_c, sc_v};
            end
          end
          RUN: begin
            cnt_q <= cnt_q - (SHW+1)'(1);
            if (is_div_q) begin
              acc_q <= div_rem_next;
              a_q   <= div_q_next;
            end else begin
              acc_q <= mul_next;
              a_q   <= a_q << 1;
              b_q   <= b_q >> 1;
            end
            if (cnt_q == (SHW+1)'(1)) begin
              result_o       <= step_res;
              flags_o[3:2]   <= {step_res[WIDTH-1], step_res == '0};
              result_valid_o <= 1'b1;
            end
          end
          default: result_valid_o <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_unit.sv
// Self-checking bench for alu_ex_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_ex_unit;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, CMP = 4'hA;
  localparam logic [3:0] MUL = 4'hB, UDIV = 4'hC;

  logic        clk, rst_n, flush_i;
  logic [3:0]  alu_op_i;
  logic [31:0] op_a_i, op_b_i;
  logic        stall_o, result_valid_o;
  logic [31:0] result_o;
  logic [3:0]  flags_o;

  logic [31:0] exp_q[$];
  logic [31:0] exp_res;
  logic [3:0]  exp_flags;
  int          n_pass, n_total;

  alu_ex_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op_i(alu_op_i), .op_a_i(op_a_i),
    .op_b_i(op_b_i), .flush_i(flush_i), .stall_o(stall_o),
    .result_o(result_o), .result_valid_o(result_valid_o), .flags_o(flags_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: updates exp_res/exp_flags from the architectural rules.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic wr);
    longint      sa, sb, s;
    logic [63:0] u;
    logic signed [31:0] sgn;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sgn = a;
    wr = 1'b1;
    r  = 32'h0;
    case (op)
      4'h1: begin
        r = a + b; s = sa + sb; u = 64'(a) + 64'(b);
        exp_flags = {r[31], r == 0, u[32], (s > 64'sd2147483647) || (s < -64'sd2147483648)};
      end
      4'h2, 4'hA: begin
        r = a - b; s = sa - sb;
        exp_flags = {r[31], r == 0, a >= b, (s > 64'sd2147483647) || (s < -64'sd2147483648)};
        wr = (op == 4'h2);
      end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = a << b[4:0];
      4'h7: r = a >> b[4:0];
      4'h8: r = sgn >>> b[4:0];
      4'h9: r = b;
      4'hB: begin u = 64'(a) * 64'(b); r = u[31:0]; end
      4'hC: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: wr = 1'b0;
    endcase
    if (wr) begin
      exp_res = r;
      exp_flags[3:2] = {r[31], r == 0};
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic wr;
    logic multi;
    int   cycles;
    multi = (op == MUL) || (op == UDIV && b != 0);
    alu_op_i = op; op_a_i = a; op_b_i = b;
    model(op, a, b, wr);
    if (wr) exp_q.push_back(exp_res);
    #1;
    check("stall_start", stall_o, multi);
    if (multi) begin
      cycles = 0;
      while (stall_o && cycles < 100) begin
        @(posedge clk); #1;
        cycles++;
        op_a_i = $urandom; op_b_i = $urandom;
        #1;
        if (stall_o) check("run_valid", result_valid_o, 1'b0);
      end
      check("stall_len", cycles, 33);
    end else begin
      @(posedge clk); #1;
    end
    check("valid", result_valid_o, wr);
    if (wr) check("result", result_o, exp_q.pop_front());
    else    check("result_hold", result_o, exp_res);
    check("flags", flags_o, exp_flags);
    if (multi) begin
      @(posedge clk); #1;
      alu_op_i = NOP;
      #1;
      check("valid_pulse", result_valid_o, 1'b0);
      check("no_relaunch", stall_o, 1'b0);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    n_pass = 0; n_total = 0;
    exp_res = 32'h0; exp_flags = 4'h0;
    rst_n = 1'b0; flush_i = 1'b0;
    alu_op_i = MUL; op_a_i = 32'd3; op_b_i = 32'd5;
    #22;
    check("rst_stall", stall_o, 1'b0);
    check("rst_result", result_o, 32'h0);
    check("rst_flags", flags_o, 4'h0);
    check("rst_valid", result_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_stall", stall_o, 1'b1);
    alu_op_i = NOP;
    @(posedge clk); #1;

    do_op(ADD, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_res", result_o, 32'h8000_0000);
    check("add_ovf_nzcv", flags_o, 4'b1001);
    do_op(SUB, 32'd5, 32'd5);
    check("sub_eq_nzcv", flags_o, 4'b0110);
    do_op(CMP, 32'd3, 32'd5);
    check("cmp_nzcv", flags_o, 4'b1000);
    check("cmp_res_hold", result_o, 32'h0);
    do_op(MUL, 32'h0001_0003, 32'h0000_0010);
    check("mul_res", result_o, 32'h0010_0030);
    do_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(UDIV, 32'd100, 32'd7);
    check("udiv_res", result_o, 32'd14);
    do_op(UDIV, 32'd5, 32'd0);
    check("udiv0_res", result_o, 32'hFFFF_FFFF);
    do_op(ADD, 32'hFFFF_FFFF, 32'h1);
    do_op(8'h08, 32'h8000_0000, 32'd31);
    do_op(4'hE, 32'h1234, 32'h5678);

    // Flush a MUL mid-run: outputs hold, unit returns to IDLE.
    alu_op_i = MUL; op_a_i = 32'd77; op_b_i = 32'd99;
    repeat (10) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    #1;
    check("flush_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0; alu_op_i = NOP;
    #1;
    check("flush_valid", result_valid_o, 1'b0);
    check("flush_res", result_o, exp_res);
    check("flush_flags", flags_o, exp_flags);
    check("flush_stall_after", stall_o, 1'b0);
    do_op(MUL, 32'd6, 32'd7);

    // Reset in the middle of a UDIV.
    alu_op_i = UDIV; op_a_i = 32'd1000; op_b_i = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", stall_o, 1'b0);
    check("mid_rst_result", result_o, 32'h0);
    check("mid_rst_flags", flags_o, 4'h0);
    check("mid_rst_valid", result_valid_o, 1'b0);
    exp_res = 32'h0; exp_flags = 4'h0;
    @(negedge clk);
    rst_n = 1'b1; alu_op_i = NOP;
    @(posedge clk); #1;
    do_op(ADD, 32'd2, 32'd3);
    check("add_after_rst", result_o, 32'd5);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      if (op == UDIV && $urandom_range(0, 4) == 0) b = 32'h0;
      do_op(op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
